mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage.sv | 91 +++++++++
 tb/tb_mem_wb_stage.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: latches the MEM result, drives the register
// file write port, answers operand hazard queries and counts retirements.
//
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   freeze             hold all stage state, including the retire counter
//   flush              load a bubble instead of the incoming instruction
//   MEM_valid          incoming instruction is valid
//   WB_en_in           incoming instruction writes a register
//   MEM_R_en_in        incoming instruction is a load
//   dest_in            incoming destination register
//   ALU_result_in      incoming ALU result
//   mem_data_in        incoming memory read data
//   src_1, src_2       hazard query operands
//   write_back_en      register-file write enable
//   WB_dest            register-file write address
//   WB_result          register-file write data
//   hazard_1/hazard_2  pending write targets src_1 / src_2
//   retired_count      number of valid instructions that left the stage
module mem_wb_stage #(
  parameter int NUM_REGS = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic        MEM_valid,
  input  logic        WB_en_in,
  input  logic        MEM_R_en_in,
  input  logic [3:0]  dest_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] mem_data_in,
  input  logic [3:0]  src_1,
  input  logic [3:0]  src_2,
  output logic        write_back_en,
  output logic [3:0]  WB_dest,
  output logic [31:0] WB_result,
  output logic        hazard_1,
  output logic        hazard_2,
  output logic [31:0] retired_count
);

  // One extra bit so NUM_REGS = 16 still lets every register through.
  localparam logic [4:0] NumRegsW = 5'(NUM_REGS);

  logic        valid_q, valid_d;
  logic        wb_en_q, wb_en_d;
  logic [3:0]  dest_q, dest_d;
  logic [31:0] result_q, result_d;
  logic [31:0] retired_q, retired_d;

  always_comb begin
    valid_d   = valid_q;
    wb_en_d   = wb_en_q;
    dest_d    = dest_q;
    result_d  = result_q;
    retired_d = retired_q;
    if (!freeze) begin
      // The instruction currently held leaves the stage on this edge.
      if (valid_q) retired_d = retired_q + 32'd1;
      valid_d  = MEM_valid & ~flush;
      wb_en_d  = WB_en_in & ~flush;
      dest_d   = dest_in;
      result_d = MEM_R_en_in ? mem_data_in : ALU_result_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      wb_en_q   <= 1'b0;
      dest_q    <= 4'd0;
      result_q  <= 32'd0;
      retired_q <= 32'd0;
    end else begin
      valid_q   <= valid_d;
      wb_en_q   <= wb_en_d;
      dest_q    <= dest_d;
      result_q  <= result_d;
      retired_q <= retired_d;
    end
  end

  assign write_back_en = valid_q & wb_en_q & ({1'b0, dest_q} < NumRegsW);
  assign WB_dest       = dest_q;
  assign WB_result     = result_q;
  assign hazard_1      = write_back_en & (src_1 == dest_q);
  assign hazard_2      = write_back_en & (src_2 == dest_q);
  assign retired_count = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage.
// Expected outputs are queued at drive time and popped after each edge.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst, freeze, flush;
  logic        MEM_valid, WB_en_in, MEM_R_en_in;
  logic [3:0]  dest_in, src_1, src_2;
  logic [31:0] ALU_result_in, mem_data_in;
  logic        write_back_en, hazard_1, hazard_2;
  logic [3:0]  WB_dest;
  logic [31:0] WB_result, retired_count;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        wbe;
    logic [3:0]  dest;
    logic [31:0] res;
    logic        h1;
    logic        h2;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  logic        m_valid, m_wben;
  logic [3:0]  m_dest;
  logic [31:0] m_res, m_cnt;

  always #5 clk = ~clk;

  mem_wb_stage #(.NUM_REGS(15)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .MEM_valid(MEM_valid), .WB_en_in(WB_en_in),
    .MEM_R_en_in(MEM_R_en_in), .dest_in(dest_in),
    .ALU_result_in(ALU_result_in), .mem_data_in(mem_data_in),
    .src_1(src_1), .src_2(src_2),
    .write_back_en(write_back_en), .WB_dest(WB_dest),
    .WB_result(WB_result), .hazard_1(hazard_1),
    .hazard_2(hazard_2), .retired_count(retired_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus at negedge, update the reference model,
  // queue the expectation, then compare just after the posedge.
  task automatic cyc(input logic r, fz, fl, v, we, ld,
                     input logic [3:0] d,
                     input logic [31:0] alu, md,
                     input logic [3:0] s1, s2);
    exp_t e, o;
    logic wbe;
    rst = r; freeze = fz; flush = fl;
    MEM_valid = v; WB_en_in = we; MEM_R_en_in = ld;
    dest_in = d; ALU_result_in = alu; mem_data_in = md;
    src_1 = s1; src_2 = s2;
    if (r) begin
      m_valid = 0; m_wben = 0; m_dest = 0;
      m_res = 0; m_cnt = 0;
    end else if (!fz) begin
      if (m_valid) m_cnt = m_cnt + 1;
      m_valid = v && !fl;
      m_wben  = we && !fl;
      m_dest  = d;
      m_res   = ld ? md : alu;
    end
    wbe = m_valid && m_wben && (m_dest != 4'd15);
    e.wbe = wbe;
    e.dest = m_dest;
    e.res = m_res;
    e.h1 = wbe && (s1 == m_dest);
    e.h2 = wbe && (s2 == m_dest);
    e.cnt = m_cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    o = sb_q.pop_front();
    chk("write_back_en", 32'(write_back_en), 32'(o.wbe));
    chk("WB_dest", 32'(WB_dest), 32'(o.dest));
    chk("WB_result", WB_result, o.res);
    chk("hazard_1", 32'(hazard_1), 32'(o.h1));
    chk("hazard_2", 32'(hazard_2), 32'(o.h2));
    chk("retired_count", retired_count, o.cnt);
    @(negedge clk);
  endtask

  initial begin
    m_valid = 0; m_wben = 0; m_dest = 0; m_res = 0; m_cnt = 0;
    @(negedge clk);

    // reset state
    cyc(1,0,0, 1,1,0, 4'd2, 32'h11, 32'h22, 4'd2, 4'd2);
    cyc(1,0,0, 1,1,0, 4'd2, 32'h11, 32'h22, 4'd0, 4'd0);

    // ALU path with hazard on src_1
    cyc(0,0,0, 1,1,0, 4'd3, 32'h1234, 32'h9, 4'd3, 4'd4);
    // load path, previous instruction retires
    cyc(0,0,0, 1,1,1, 4'd4, 32'h40, 32'hDEADBEEF, 4'd4, 4'd1);

    // back-to-back random loads / ALU ops
    for (int i = 0; i < 8; i++)
      cyc(0,0,0, 1, 1'($urandom), 1'($urandom),
          4'($urandom_range(0,14)), $urandom, $urandom,
          4'($urandom), 4'($urandom));

    // freeze+flush hold of a dest=5 instruction
    cyc(0,0,0, 1,1,0, 4'd5, 32'h5555, 32'h0, 4'd5, 4'd5);
    for (int i = 0; i < 3; i++)
      cyc(0,1,1, 1,1, 1'(i), 4'(i + 8), $urandom, $urandom,
          4'd5, 4'd6);
    cyc(0,0,1, 1,1,0, 4'd6, 32'h66, 32'h0, 4'd6, 4'd5);

    // R15 guard
    cyc(0,0,0, 1,1,0, 4'd15, 32'hF00D, 32'h0, 4'd15, 4'd15);
    // valid but no write, both hazards on a real write
    cyc(0,0,0, 1,0,0, 4'd7, 32'h77, 32'h0, 4'd7, 4'd7);
    cyc(0,0,0, 1,1,0, 4'd7, 32'h78, 32'h0, 4'd7, 4'd7);
    // invalid instruction does not count on leaving
    cyc(0,0,0, 0,1,0, 4'd1, 32'h1, 32'h0, 4'd1, 4'd1);
    cyc(0,0,0, 1,1,1, 4'd9, 32'h0, 32'hCAFE, 4'd9, 4'd0);

    // reset mid-stream, including while frozen
    cyc(1,1,0, 1,1,0, 4'd2, 32'hAA, 32'h0, 4'd9, 4'd0);
    cyc(0,0,0, 1,1,0, 4'd2, 32'hAB, 32'h0, 4'd2, 4'd0);

    // retire counter wrap: preload just below the top
    dut.retired_q = 32'hFFFFFFFE;
    m_cnt = 32'hFFFFFFFE;
    cyc(0,0,0, 1,1,0, 4'd1, 32'h10, 32'h0, 4'd1, 4'd0);
    cyc(0,0,0, 1,1,0, 4'd2, 32'h20, 32'h0, 4'd2, 4'd0);
    cyc(0,0,0, 1,1,0, 4'd3, 32'h30, 32'h0, 4'd3, 4'd0);

    // random tail including freeze/flush/reset mixes
    for (int i = 0; i < 40; i++)
      cyc(($urandom_range(0,15) == 0), 1'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom),
          4'($urandom), $urandom, $urandom,
          4'($urandom), 4'($urandom));

    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
